regfile_reader: RTL

REGFILE_READER -- requirements
Module: regfile_reader

---
 rtl/regfile_reader_if.sv | 34 +++
 rtl/regfile_reader.sv | 102 ++++++++++
 2 files changed

// File: rtl/regfile_reader_if.sv
// regfile_reader_if: bundles the dump control, regfile read port and the
// output word handshake of regfile_reader.
//   start/first_reg/count/abort : dump request and cancel
//   rd_addr/rd_data             : combinational regfile read port
//   out_data/out_reg/out_valid/out_ready : presented word and its handshake
//   busy/done                   : status
// slave is the reader side, master is the controller/regfile/sink side.
interface regfile_reader_if #(
  parameter int WIDTH = 64,
  parameter int ADDR  = 5
);
  logic              start;
  logic [ADDR-1:0]   first_reg;
  logic [ADDR:0]     count;
  logic              abort;
  logic [ADDR-1:0]   rd_addr;
  logic [WIDTH-1:0]  rd_data;
  logic [WIDTH-1:0]  out_data;
  logic [ADDR-1:0]   out_reg;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;

  modport master (
    output start, first_reg, count, abort, rd_data, out_ready,
    input  rd_addr, out_data, out_reg, out_valid, busy, done
  );

  modport slave (
    input  start, first_reg, count, abort, rd_data, out_ready,
    output rd_addr, out_data, out_reg, out_valid, busy, done
  );
endinterface

// File: rtl/regfile_reader.sv
// regfile_reader: dumps a run of consecutive registers (wrapping at the top
// of the file) out through a valid/ready word interface.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : regfile_reader_if.slave (request, regfile read port, output word,
//          busy/done status)
// Each word takes one READ cycle (address presented, data registered) and
// at least one HOLD cycle (word presented until accepted).
module regfile_reader #(
  parameter int WIDTH = 64,
  parameter int ADDR  = 5
) (
  input logic              clk,
  input logic              rst,
  regfile_reader_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, READ, HOLD, DONE} state_t;

  localparam logic [ADDR:0] MAX_CNT = {1'b1, {ADDR{1'b0}}};

  state_t            state, state_next;
  logic [ADDR-1:0]   cur;
  logic [ADDR:0]     remaining;
  logic [WIDTH-1:0]  out_data_q;
  logic [ADDR-1:0]   out_reg_q;
  logic              out_valid_q;
  logic              xfer;
  logic              last_word;

  assign xfer      = out_valid_q && bus.out_ready;
  assign last_word = (remaining == (ADDR+1)'(1));

  // cur only moves at an accepted start or a non-aborted transfer, so it
  // already holds the last read address everywhere outside READ.
  assign bus.rd_addr   = cur;
  assign bus.out_data  = out_data_q;
  assign bus.out_reg   = out_reg_q;
  assign bus.out_valid = out_valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (bus.start) state_next = (bus.count != '0) ? READ : DONE;
      READ: state_next = bus.abort ? IDLE : HOLD;
      HOLD: begin
        if (bus.abort)  state_next = IDLE;
        else if (xfer)  state_next = last_word ? DONE : READ;
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state != IDLE);
    bus.done = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur         <= '0;
      remaining   <= '0;
      out_data_q  <= '0;
      out_reg_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start && bus.count != '0) begin
            cur       <= bus.first_reg;
            remaining <= (bus.count > MAX_CNT) ? MAX_CNT : bus.count;
          end
        end
        READ: begin
          if (!bus.abort) begin
            out_data_q  <= bus.rd_data;
            out_reg_q   <= cur;
            out_valid_q <= 1'b1;
          end
        end
        HOLD: begin
          // A transfer coinciding with abort still consumes the word, but
          // the address is left on the word that was delivered.
          if (xfer) begin
            remaining   <= remaining - (ADDR+1)'(1);
            out_valid_q <= 1'b0;
            if (!bus.abort && !last_word) cur <= cur + ADDR'(1);
          end
          if (bus.abort) out_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
